// File: rtl/mem_access_unit.sv
// ============================================================================
//  Module      : mem_access_unit
//  Description : Byte-serial memory access sequencer. Accepts a 16-bit word
//                address and read/write command, performs two byte transfers
//                over a req/ack memory port (low byte at Addr, high byte at
//                Addr+1, little-endian) and returns the assembled read word
//                with a one-cycle Done pulse.
//  Options     : MAU_TIMEOUT_EN - enables the per-byte MemAck watchdog
//                (TIMEOUT cycles); when undefined Err is tied low.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_access_unit #(
    parameter int TIMEOUT = 15
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic [15:0] Addr,
    input  logic [15:0] WData,
    input  logic        Start,
    input  logic        Write,
    output logic        Busy,
    output logic        Done,
    output logic [15:0] RData,
    output logic        Err,
    output logic [15:0] MemAddr,
    output logic [7:0]  MemWData,
    output logic        MemReq,
    output logic        MemWr,
    input  logic [7:0]  MemRData,
    input  logic        MemAck
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LO   = 2'd1,
        S_HI   = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t      state_q,     state_d;
    logic [15:0] mem_addr_q,  mem_addr_d;
    logic [7:0]  mem_wdata_q, mem_wdata_d;
    logic [7:0]  wdata_hi_q,  wdata_hi_d;
    logic [7:0]  lo_byte_q,   lo_byte_d;
    logic [15:0] rdata_q,     rdata_d;
    logic        write_q,     write_d;
    logic        w_in_xfer;

`ifdef MAU_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    // Abort happens on the edge that closes the TIMEOUT-th wait cycle.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT > 0);
`endif

    assign w_in_xfer = (state_q == S_LO) || (state_q == S_HI);

    // Outputs are decoded from registered state only; nothing from MemAck/MemRData reaches them combinationally.
    assign Busy     = w_in_xfer;
    assign MemReq   = w_in_xfer;
    assign MemWr    = w_in_xfer & write_q;
    assign Done     = (state_q == S_DONE);
    assign RData    = rdata_q;
    assign MemAddr  = mem_addr_q;
    assign MemWData = mem_wdata_q;
`ifdef MAU_TIMEOUT_EN
    assign Err      = err_q;
`else
    assign Err      = 1'b0;
`endif

    // Next-state and datapath: command latch, byte sequencing and read-word assembly.
    always_comb begin
        state_d     = state_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        wdata_hi_d  = wdata_hi_q;
        lo_byte_d   = lo_byte_q;
        rdata_d     = rdata_q;
        write_d     = write_q;
`ifdef MAU_TIMEOUT_EN
        cnt_d       = cnt_q;
        err_d       = err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    state_d     = S_LO;
                    mem_addr_d  = Addr;
                    mem_wdata_d = WData[7:0];
                    wdata_hi_d  = WData[15:8];
                    write_d     = Write;
`ifdef MAU_TIMEOUT_EN
                    cnt_d       = '0;
                    err_d       = 1'b0;
`endif
                end
            end
            S_LO: begin
                if (MemAck) begin
                    state_d     = S_HI;
                    // Addition wraps modulo 2^16, so 0xFFFF is followed by 0x0000.
                    mem_addr_d  = mem_addr_q + 16'd1;
                    mem_wdata_d = wdata_hi_q;
                    if (!write_q) begin
                        lo_byte_d = MemRData;
                    end
`ifdef MAU_TIMEOUT_EN
                    cnt_d       = '0;
`endif
                end
`ifdef MAU_TIMEOUT_EN
                else if (cnt_q == CNT_LAST) begin
                    state_d = S_DONE;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            S_HI: begin
                if (MemAck) begin
                    state_d = S_DONE;
                    if (!write_q) begin
                        rdata_d = {MemRData, lo_byte_q};
                    end
`ifdef MAU_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
`ifdef MAU_TIMEOUT_EN
                else if (cnt_q == CNT_LAST) begin
                    state_d = S_DONE;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset is asynchronous so MemReq drops without a clock.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q     <= S_IDLE;
            mem_addr_q  <= 16'h0000;
            mem_wdata_q <= 8'h00;
            wdata_hi_q  <= 8'h00;
            lo_byte_q   <= 8'h00;
            rdata_q     <= 16'h0000;
            write_q     <= 1'b0;
`ifdef MAU_TIMEOUT_EN
            cnt_q       <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            wdata_hi_q  <= wdata_hi_d;
            lo_byte_q   <= lo_byte_d;
            rdata_q     <= rdata_d;
            write_q     <= write_d;
`ifdef MAU_TIMEOUT_EN
            cnt_q       <= cnt_d;
            err_q       <= err_d;
`endif
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_access_unit.sv
// ============================================================================
//  Module      : tb_mem_access_unit
//  Description : Directed self-checking bench for mem_access_unit with a
//                byte-wide memory responder supporting wait states.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_access_unit;

    logic        Clock;
    logic        Reset;
    logic [15:0] Addr;
    logic [15:0] WData;
    logic        Start;
    logic        Write;
    logic        Busy;
    logic        Done;
    logic [15:0] RData;
    logic        Err;
    logic [15:0] MemAddr;
    logic [7:0]  MemWData;
    logic        MemReq;
    logic        MemWr;
    logic [7:0]  MemRData = 8'h00;
    logic        MemAck   = 1'b0;

    int checks = 0;
    int errors = 0;

    // Memory model and responder controls
    logic [7:0]  mem [0:65535];
    int          wait_cfg  = 0;
    bit          ack_stuck = 1'b0;
    bit          force_ack = 1'b0;
    int          wcnt      = 0;

    // Handshake log
    logic [15:0] log_addr  [0:63];
    logic [7:0]  log_wdata [0:63];
    logic        log_wr    [0:63];
    int          n_xfer    = 0;

    mem_access_unit #(.TIMEOUT(15)) dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .Addr     (Addr),
        .WData    (WData),
        .Start    (Start),
        .Write    (Write),
        .Busy     (Busy),
        .Done     (Done),
        .RData    (RData),
        .Err      (Err),
        .MemAddr  (MemAddr),
        .MemWData (MemWData),
        .MemReq   (MemReq),
        .MemWr    (MemWr),
        .MemRData (MemRData),
        .MemAck   (MemAck)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Responder: inserts wait_cfg wait cycles per byte, then acks with read data.
    always @(negedge Clock) begin
        if (MemAck) wcnt = 0;
        if (MemReq && !ack_stuck) begin
            if (wcnt >= wait_cfg) begin
                MemAck   = 1'b1;
                MemRData = mem[MemAddr];
            end else begin
                MemAck   = 1'b0;
                MemRData = 8'h00;
                wcnt     = wcnt + 1;
            end
        end else begin
            MemAck   = force_ack;
            MemRData = 8'hFF;
            wcnt     = 0;
        end
    end

    // Logger: records every completed handshake.
    always @(posedge Clock) begin
        if (Reset && MemReq && MemAck) begin
            log_addr[n_xfer % 64]  <= MemAddr;
            log_wdata[n_xfer % 64] <= MemWData;
            log_wr[n_xfer % 64]    <= MemWr;
            n_xfer                 <= n_xfer + 1;
        end
    end

    // Issues a one-cycle Start; returns at the falling edge of cycle 1.
    task automatic issue(input logic [15:0] a, input logic [15:0] d, input logic w);
        @(negedge Clock);
        Addr  = a;
        WData = d;
        Write = w;
        Start = 1'b1;
        @(negedge Clock);
        Start = 1'b0;
    endtask

    // Bounded wait for Done; cyc is the cycle index (1 = first LO cycle).
    task automatic wait_done(output int cyc);
        cyc = 1;
        while (!Done && cyc < 60) begin
            @(negedge Clock);
            cyc = cyc + 1;
        end
    endtask

    task automatic test_reset;
        Reset = 1'b0; Start = 1'b0; Write = 1'b0; Addr = 16'h0; WData = 16'h0;
        #12;
        checks++; if (Busy !== 1'b0)      begin errors++; $display("FAIL reset_busy got %0b exp 0", Busy); end
        checks++; if (Done !== 1'b0)      begin errors++; $display("FAIL reset_done got %0b exp 0", Done); end
        checks++; if (Err !== 1'b0)       begin errors++; $display("FAIL reset_err got %0b exp 0", Err); end
        checks++; if (RData !== 16'h0)    begin errors++; $display("FAIL reset_rdata got %h exp 0000", RData); end
        checks++; if (MemAddr !== 16'h0)  begin errors++; $display("FAIL reset_memaddr got %h exp 0000", MemAddr); end
        checks++; if (MemWData !== 8'h0)  begin errors++; $display("FAIL reset_memwdata got %h exp 00", MemWData); end
        checks++; if (MemReq !== 1'b0)    begin errors++; $display("FAIL reset_memreq got %0b exp 0", MemReq); end
        checks++; if (MemWr !== 1'b0)     begin errors++; $display("FAIL reset_memwr got %0b exp 0", MemWr); end
        @(negedge Clock);
        Reset = 1'b1;
        @(negedge Clock);
    endtask

    task automatic test_zero_wait_read;
        wait_cfg = 0;
        issue(16'h1234, 16'h0000, 1'b0);
        checks++; if (MemReq !== 1'b1 || Busy !== 1'b1) begin errors++; $display("FAIL zw_c1_req got req=%0b busy=%0b exp 1/1", MemReq, Busy); end
        checks++; if (MemAddr !== 16'h1234) begin errors++; $display("FAIL zw_c1_addr got %h exp 1234", MemAddr); end
        checks++; if (MemWr !== 1'b0)       begin errors++; $display("FAIL zw_c1_wr got %0b exp 0", MemWr); end
        @(negedge Clock);
        checks++; if (MemAddr !== 16'h1235 || MemReq !== 1'b1) begin errors++; $display("FAIL zw_c2_addr got %h req=%0b exp 1235 req=1", MemAddr, MemReq); end
        checks++; if (Done !== 1'b0)        begin errors++; $display("FAIL zw_c2_done got %0b exp 0", Done); end
        @(negedge Clock);
        checks++; if (Done !== 1'b1 || Busy !== 1'b0 || MemReq !== 1'b0) begin errors++; $display("FAIL zw_c3_done got done=%0b busy=%0b req=%0b exp 1/0/0", Done, Busy, MemReq); end
        checks++; if (RData !== 16'hABCD)   begin errors++; $display("FAIL zw_c3_rdata got %h exp abcd", RData); end
        checks++; if (MemAddr !== 16'h1235) begin errors++; $display("FAIL zw_c3_addr_hold got %h exp 1235", MemAddr); end
        @(negedge Clock);
        checks++; if (Done !== 1'b0)        begin errors++; $display("FAIL zw_c4_done got %0b exp 0", Done); end
    endtask

    task automatic test_write_wait;
        int base;
        int cyc;
        wait_cfg = 2;
        base = n_xfer;
        issue(16'h0040, 16'hBEEF, 1'b1);
        checks++; if (MemWr !== 1'b1 || MemWData !== 8'hEF) begin errors++; $display("FAIL wr_c1 got wr=%0b wd=%h exp 1/ef", MemWr, MemWData); end
        wait_done(cyc);
        checks++; if (cyc !== 7)            begin errors++; $display("FAIL wr_done_cycle got %0d exp 7", cyc); end
        checks++; if (RData !== 16'hABCD)   begin errors++; $display("FAIL wr_rdata_hold got %h exp abcd", RData); end
        checks++; if (n_xfer - base !== 2)  begin errors++; $display("FAIL wr_xfer_count got %0d exp 2", n_xfer - base); end
        checks++; if (log_addr[base % 64] !== 16'h0040 || log_wdata[base % 64] !== 8'hEF || log_wr[base % 64] !== 1'b1)
            begin errors++; $display("FAIL wr_byte0 got %h/%h/%0b exp 0040/ef/1", log_addr[base % 64], log_wdata[base % 64], log_wr[base % 64]); end
        checks++; if (log_addr[(base + 1) % 64] !== 16'h0041 || log_wdata[(base + 1) % 64] !== 8'hBE || log_wr[(base + 1) % 64] !== 1'b1)
            begin errors++; $display("FAIL wr_byte1 got %h/%h/%0b exp 0041/be/1", log_addr[(base + 1) % 64], log_wdata[(base + 1) % 64], log_wr[(base + 1) % 64]); end
    endtask

    task automatic test_wrap;
        int base;
        int cyc;
        wait_cfg = 0;
        base = n_xfer;
        issue(16'hFFFF, 16'h0000, 1'b0);
        wait_done(cyc);
        checks++; if (cyc !== 3)            begin errors++; $display("FAIL wrap_done_cycle got %0d exp 3", cyc); end
        checks++; if (RData !== 16'h3C5A)   begin errors++; $display("FAIL wrap_rdata got %h exp 3c5a", RData); end
        checks++; if (log_addr[base % 64] !== 16'hFFFF || log_addr[(base + 1) % 64] !== 16'h0000)
            begin errors++; $display("FAIL wrap_addrs got %h,%h exp ffff,0000", log_addr[base % 64], log_addr[(base + 1) % 64]); end
    endtask

    task automatic test_start_during_busy;
        int base;
        int done_cnt;
        int done_cyc;
        wait_cfg = 1;
        base = n_xfer;
        done_cnt = 0;
        done_cyc = 0;
        issue(16'h0100, 16'h0000, 1'b0);
        @(negedge Clock);
        Addr = 16'h2000; WData = 16'h5555; Write = 1'b1; Start = 1'b1;
        @(negedge Clock);
        Start = 1'b0;
        for (int c = 3; c <= 14; c++) begin
            if (Done) begin done_cnt++; done_cyc = c; end
            @(negedge Clock);
        end
        checks++; if (done_cnt !== 1)       begin errors++; $display("FAIL busy_done_count got %0d exp 1", done_cnt); end
        checks++; if (done_cyc !== 5)       begin errors++; $display("FAIL busy_done_cycle got %0d exp 5", done_cyc); end
        checks++; if (n_xfer - base !== 2)  begin errors++; $display("FAIL busy_xfer_count got %0d exp 2", n_xfer - base); end
        checks++; if (log_wr[base % 64] !== 1'b0 || log_wr[(base + 1) % 64] !== 1'b0 || log_addr[(base + 1) % 64] !== 16'h0101)
            begin errors++; $display("FAIL busy_xfers got wr=%0b%0b a1=%h exp 00 0101", log_wr[base % 64], log_wr[(base + 1) % 64], log_addr[(base + 1) % 64]); end
        checks++; if (RData !== 16'h2211)   begin errors++; $display("FAIL busy_rdata got %h exp 2211", RData); end
    endtask

    task automatic test_back_to_back;
        int base;
        logic [15:0] mask;
        wait_cfg = 0;
        base = n_xfer;
        mask = 16'h0;
        @(negedge Clock);
        Addr = 16'h1234; WData = 16'h0; Write = 1'b0; Start = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            @(negedge Clock);
            if (c == 9) Start = 1'b0;
            if (Done) mask[c] = 1'b1;
        end
        checks++; if (mask !== 16'h0888)    begin errors++; $display("FAIL b2b_done_mask got %h exp 0888", mask); end
        checks++; if (n_xfer - base !== 6)  begin errors++; $display("FAIL b2b_xfer_count got %0d exp 6", n_xfer - base); end
        checks++; if (RData !== 16'hABCD)   begin errors++; $display("FAIL b2b_rdata got %h exp abcd", RData); end
    endtask

    task automatic test_idle_ack;
        int base;
        int bad;
        base = n_xfer;
        bad = 0;
        force_ack = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge Clock);
            if (Busy || Done || MemReq) bad++;
        end
        force_ack = 1'b0;
        @(negedge Clock);
        checks++; if (bad !== 0)            begin errors++; $display("FAIL idle_ack_activity got %0d exp 0", bad); end
        checks++; if (n_xfer !== base)      begin errors++; $display("FAIL idle_ack_xfers got %0d exp %0d", n_xfer, base); end
    endtask

    task automatic test_reset_mid_hi;
        int cyc;
        wait_cfg = 3;
        issue(16'h1234, 16'h0000, 1'b0);
        // LO spans cycles 1..4, HI starts in cycle 5
        repeat (5) @(negedge Clock);
        checks++; if (MemAddr !== 16'h1235 || MemReq !== 1'b1) begin errors++; $display("FAIL rst_pre_hi got %h req=%0b exp 1235 req=1", MemAddr, MemReq); end
        #2;
        Reset = 1'b0;
        #1;
        checks++; if (MemReq !== 1'b0 || Busy !== 1'b0 || Done !== 1'b0) begin errors++; $display("FAIL rst_async got req=%0b busy=%0b done=%0b exp 0/0/0", MemReq, Busy, Done); end
        checks++; if (MemAddr !== 16'h0 || MemWData !== 8'h0 || RData !== 16'h0) begin errors++; $display("FAIL rst_async_data got %h/%h/%h exp 0000/00/0000", MemAddr, MemWData, RData); end
        @(negedge Clock);
        Reset = 1'b1;
        @(negedge Clock);
        checks++; if (Busy !== 1'b0 || MemReq !== 1'b0) begin errors++; $display("FAIL rst_release_idle got busy=%0b req=%0b exp 0/0", Busy, MemReq); end
        wait_cfg = 0;
        issue(16'h1234, 16'h0000, 1'b0);
        wait_done(cyc);
        checks++; if (cyc !== 3 || RData !== 16'hABCD) begin errors++; $display("FAIL rst_after_read got cyc=%0d rdata=%h exp 3 abcd", cyc, RData); end
        @(negedge Clock);
    endtask

`ifdef MAU_TIMEOUT_EN
    task automatic test_timeout;
        int cyc;
        ack_stuck = 1'b1;
        issue(16'h0100, 16'h0000, 1'b0);
        wait_done(cyc);
        checks++; if (cyc !== 16)           begin errors++; $display("FAIL to_done_cycle got %0d exp 16", cyc); end
        checks++; if (Err !== 1'b1)         begin errors++; $display("FAIL to_err got %0b exp 1", Err); end
        checks++; if (RData !== 16'hABCD)   begin errors++; $display("FAIL to_rdata_hold got %h exp abcd", RData); end
        ack_stuck = 1'b0;
        repeat (2) @(negedge Clock);
        checks++; if (Err !== 1'b1)         begin errors++; $display("FAIL to_err_sticky got %0b exp 1", Err); end
        issue(16'h0100, 16'h0000, 1'b0);
        checks++; if (Err !== 1'b0)         begin errors++; $display("FAIL to_err_clear got %0b exp 0", Err); end
        wait_done(cyc);
        checks++; if (cyc !== 3 || RData !== 16'h2211) begin errors++; $display("FAIL to_recover got cyc=%0d rdata=%h exp 3 2211", cyc, RData); end
        @(negedge Clock);
    endtask
`endif

    initial begin
        mem[16'h1234] = 8'hCD;
        mem[16'h1235] = 8'hAB;
        mem[16'hFFFF] = 8'h5A;
        mem[16'h0000] = 8'h3C;
        mem[16'h0100] = 8'h11;
        mem[16'h0101] = 8'h22;
        test_reset();
        test_zero_wait_read();
        test_write_wait();
        test_wrap();
        test_start_during_busy();
        test_back_to_back();
        test_idle_ack();
        test_reset_mid_hi();
`ifdef MAU_TIMEOUT_EN
        test_timeout();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global guard against a stalled run.
    initial begin
        #200000;
        $display("FAIL global_timeout got stalled exp finish");
        $fatal(1);
    end

endmodule

`default_nettype wire
